bp_btb_unit: RTL and testbench

BP_BTB_UNIT -- requirements
Module: bp_btb_unit

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_ras.sv | 52 +++++
 rtl/bp_btb_unit.sv | 116 +++++++++++
 tb/tb_bp_btb_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: meta layout, counter init, saturating update.
package bp_pkg;

  localparam int unsigned MAX_IDX_W = 16;
  localparam int unsigned MAX_CTR_W = 4;

  // Widest-case view of the meta word; the top packs it as {idx, ctr} at its own widths.
  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_CTR_W-1:0] ctr;
  } bp_meta_t;

  // Freshly allocated entries start weakly taken.
  function automatic logic [MAX_CTR_W-1:0] ctr_init(input int unsigned ctrW);
    return MAX_CTR_W'(1) << (ctrW - 1);
  endfunction

  function automatic logic [MAX_CTR_W-1:0] next_ctr(input logic [MAX_CTR_W-1:0] ctr,
                                                    input logic taken,
                                                    input int unsigned ctrW);
    logic [MAX_CTR_W-1:0] maxV;
    maxV = MAX_CTR_W'((1 << ctrW) - 1);
    if (taken) return (ctr == maxV) ? ctr : ctr + 1'b1;
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Return-address stack: circular buffer that overwrites its oldest entry on overflow.
module bp_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  stack_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, popPtr;
  logic [CNT_W-1:0] count_q, count_d, popCount;

  // ptr_q is the next free slot; a simultaneous call and return pops first, then pushes.
  always_comb begin
    popPtr   = ptr_q;
    popCount = count_q;
    if (pop && count_q != '0) begin
      popPtr   = ptr_q - 1'b1;
      popCount = count_q - 1'b1;
    end
    ptr_d   = popPtr;
    count_d = popCount;
    if (push) begin
      ptr_d   = popPtr + 1'b1;
      count_d = (popCount == CNT_W'(DEPTH)) ? popCount : popCount + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (push) stack_q[popPtr] <= push_data;
    end
  end

  assign top   = stack_q[ptr_q - 1'b1];
  assign empty = (count_q == '0);

endmodule

// File: rtl/bp_btb_unit.sv
// Branch target buffer with saturating counters, optional gshare indexing and,
// when BP_RAS_EN is defined, a return-address stack for return prediction.
module bp_btb_unit
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int CTR_W     = 2,
  parameter int GSHARE    = 0,
  parameter int RAS_DEPTH = 4,
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int META_W   = IDX_W + CTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              pred_taken,
  output logic              pred_hit,
  output logic [XLEN-1:0]   pred_target,
  output logic [META_W-1:0] pred_meta,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_taken,
  input  logic              upd_is_call,
  input  logic              upd_is_ret,
  input  logic [META_W-1:0] upd_meta,
  input  logic              bp_clear
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [ENTRIES-1:0] isRet_q;
  logic [IDX_W-1:0]   ghr_q;

  logic [IDX_W-1:0] fetchIdx, updIdx;
  logic [TAG_W-1:0] fetchTag, updTag;
  logic             rdHit, rdRet, updHit;
  logic [CTR_W-1:0] rdCtr;
  logic [XLEN-1:0]  seqPc;

  assign fetchIdx = (GSHARE != 0) ? (fetch_pc[2 +: IDX_W] ^ ghr_q) : fetch_pc[2 +: IDX_W];
  assign fetchTag = fetch_pc[2+IDX_W +: TAG_W];
  assign rdHit    = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
  assign rdCtr    = ctr_q[fetchIdx];
  assign rdRet    = isRet_q[fetchIdx];
  assign seqPc    = fetch_pc + XLEN'(4);

  assign pred_hit  = rdHit;
  assign pred_meta = {fetchIdx, rdCtr};

  // The update trusts the index carried in meta, since ghr may have moved since the fetch.
  assign updIdx = upd_meta[CTR_W +: IDX_W];
  assign updTag = upd_pc[2+IDX_W +: TAG_W];
  assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

`ifdef BP_RAS_EN
  logic [XLEN-1:0] rasTop;
  logic            rasEmpty;

  bp_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (upd_valid && upd_is_call && !bp_clear),
    .pop       (upd_valid && upd_is_ret && !bp_clear),
    .push_data (upd_pc + XLEN'(4)),
    .top       (rasTop),
    .empty     (rasEmpty)
  );

  assign pred_taken  = rdHit && (rdCtr[CTR_W-1] || rdRet);
  assign pred_target = !pred_taken ? seqPc :
                       (rdRet && !rasEmpty) ? rasTop : target_q[fetchIdx];
`else
  logic unused_ret;
  assign unused_ret  = rdRet;
  assign pred_taken  = rdHit && rdCtr[CTR_W-1];
  assign pred_target = pred_taken ? target_q[fetchIdx] : seqPc;
`endif

  // Table and history update; clear beats a concurrent update, reset discards it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      isRet_q <= '0;
      ghr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (bp_clear) begin
      valid_q <= '0;
      ghr_q   <= '0;
    end else if (upd_valid) begin
      if (GSHARE != 0) ghr_q <= IDX_W'({ghr_q, upd_taken});
      if (updHit) begin
        ctr_q[updIdx] <= CTR_W'(next_ctr(MAX_CTR_W'(ctr_q[updIdx]), upd_taken, CTR_W));
        if (upd_taken) target_q[updIdx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[updIdx]  <= 1'b1;
        tag_q[updIdx]    <= updTag;
        target_q[updIdx] <= upd_target;
        ctr_q[updIdx]    <= CTR_W'(ctr_init(CTR_W));
        isRet_q[updIdx]  <= upd_is_ret;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{fetch_pc, upd_pc, upd_meta, upd_is_call};

endmodule

// File: tb/tb_bp_btb_unit.sv
// Directed bench for bp_btb_unit: a default instance plus a GSHARE=1 instance on shared inputs.
module tb_bp_btb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        upd_is_call = 1'b0;
  logic        upd_is_ret = 1'b0;
  logic [5:0]  upd_meta = '0;
  logic        bp_clear = 1'b0;

  logic        predTaken, predHit, gPredTaken, gPredHit;
  logic [31:0] predTarget, gPredTarget;
  logic [5:0]  predMeta, gPredMeta;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  bp_btb_unit dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(predTaken), .pred_hit(predHit), .pred_target(predTarget), .pred_meta(predMeta),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_is_call(upd_is_call), .upd_is_ret(upd_is_ret), .upd_meta(upd_meta), .bp_clear(bp_clear)
  );

  bp_btb_unit #(.GSHARE(1)) dutG (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(gPredTaken), .pred_hit(gPredHit), .pred_target(gPredTarget), .pred_meta(gPredMeta),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_is_call(upd_is_call), .upd_is_ret(upd_is_ret), .upd_meta(upd_meta), .bp_clear(bp_clear)
  );

  // Meta for a non-gshare lookup: {pc[5:2], ctr}.
  function automatic logic [5:0] metaOf(input logic [31:0] pc);
    return {pc[5:2], 2'b00};
  endfunction

  // Drives one update for exactly one rising edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                               input logic call, input logic ret, input logic [5:0] meta);
    upd_pc = pc; upd_target = tgt; upd_taken = taken;
    upd_is_call = call; upd_is_ret = ret; upd_meta = meta; upd_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_is_call = 1'b0; upd_is_ret = 1'b0; upd_taken = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_pc = pc; #1;
  endtask

  task automatic pulseReset();
    @(negedge clk); rst = 1'b0; #2; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch(32'h40);
    testsRun++; if (predHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_hit: got %b expected 0", predHit); end
    testsRun++; if (predTaken !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_taken: got %b expected 0", predTaken); end
    testsRun++; if (predTarget !== 32'h44) begin testsFailed++; $display("[TB] FAIL reset_target: got %h expected 00000044", predTarget); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_counter();
    applyStimulus(32'h40, 32'h80, 1'b1, 1'b0, 1'b0, metaOf(32'h40));
    fetch(32'h40);
    testsRun++; if (predHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL alloc_hit: got %b expected 1", predHit); end
    testsRun++; if (predTaken !== 1'b1) begin testsFailed++; $display("[TB] FAIL alloc_taken: got %b expected 1", predTaken); end
    testsRun++; if (predTarget !== 32'h80) begin testsFailed++; $display("[TB] FAIL alloc_target: got %h expected 00000080", predTarget); end
    testsRun++; if (predMeta !== 6'b0000_10) begin testsFailed++; $display("[TB] FAIL alloc_meta: got %b expected 000010", predMeta); end
    for (int i = 0; i < 2; i++) applyStimulus(32'h40, 32'h0, 1'b0, 1'b0, 1'b0, metaOf(32'h40));
    fetch(32'h40);
    testsRun++; if (predMeta !== 6'b0000_00) begin testsFailed++; $display("[TB] FAIL dec_ctr: got %b expected 000000", predMeta); end
    testsRun++; if (predTaken !== 1'b0) begin testsFailed++; $display("[TB] FAIL dec_taken: got %b expected 0", predTaken); end
    testsRun++; if (predTarget !== 32'h44) begin testsFailed++; $display("[TB] FAIL dec_target: got %h expected 00000044", predTarget); end
    testsRun++; if (predHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL dec_hit: got %b expected 1", predHit); end
    for (int i = 0; i < 5; i++) applyStimulus(32'h40, 32'h90, 1'b1, 1'b0, 1'b0, metaOf(32'h40));
    fetch(32'h40);
    testsRun++; if (predMeta !== 6'b0000_11) begin testsFailed++; $display("[TB] FAIL sat_ctr: got %b expected 000011", predMeta); end
    testsRun++; if (predTarget !== 32'h90) begin testsFailed++; $display("[TB] FAIL sat_target: got %h expected 00000090", predTarget); end
  endtask

  task automatic test_miss_no_alloc();
    applyStimulus(32'h100, 32'h200, 1'b0, 1'b0, 1'b0, metaOf(32'h100));
    fetch(32'h100);
    testsRun++; if (predHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL noalloc_hit: got %b expected 0", predHit); end
    testsRun++; if (predTarget !== 32'h104) begin testsFailed++; $display("[TB] FAIL noalloc_target: got %h expected 00000104", predTarget); end
    fetch(32'h40);
    testsRun++; if (predMeta !== 6'b0000_11 || predHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL noalloc_keep: got hit=%b meta=%b expected hit=1 meta=000011", predHit, predMeta); end
  endtask

  task automatic test_same_cycle();
    fetch(32'h40);
    upd_pc = 32'h40; upd_target = 32'hA0; upd_taken = 1'b1; upd_meta = metaOf(32'h40); upd_valid = 1'b1;
    #1;
    testsRun++; if (predTarget !== 32'h90) begin testsFailed++; $display("[TB] FAIL same_cycle_pre: got %h expected 00000090", predTarget); end
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_taken = 1'b0;
    testsRun++; if (predTarget !== 32'hA0) begin testsFailed++; $display("[TB] FAIL same_cycle_post: got %h expected 000000a0", predTarget); end
  endtask

  task automatic test_return();
    applyStimulus(32'h204, 32'h300, 1'b1, 1'b0, 1'b1, metaOf(32'h204));
`ifdef BP_RAS_EN
    for (int i = 1; i <= 5; i++)
      applyStimulus(32'h10 * i, 32'h800, 1'b1, 1'b1, 1'b0, metaOf(32'h10 * i));
    fetch(32'h204);
    testsRun++; if (predTarget !== 32'h54 || predTaken !== 1'b1) begin testsFailed++; $display("[TB] FAIL ras_top: got taken=%b target=%h expected taken=1 target=00000054", predTaken, predTarget); end
    applyStimulus(32'h204, 32'h300, 1'b1, 1'b0, 1'b1, metaOf(32'h204));
    fetch(32'h204);
    testsRun++; if (predTarget !== 32'h44) begin testsFailed++; $display("[TB] FAIL ras_pop: got %h expected 00000044", predTarget); end
    for (int i = 0; i < 3; i++) applyStimulus(32'h204, 32'h300, 1'b1, 1'b0, 1'b1, metaOf(32'h204));
    fetch(32'h204);
    testsRun++; if (predTarget !== 32'h300) begin testsFailed++; $display("[TB] FAIL ras_empty: got %h expected 00000300", predTarget); end
    for (int i = 0; i < 2; i++) applyStimulus(32'h204, 32'h0, 1'b0, 1'b0, 1'b1, metaOf(32'h204));
    fetch(32'h204);
    testsRun++; if (predTaken !== 1'b1 || predMeta !== 6'b0001_01) begin testsFailed++; $display("[TB] FAIL ret_forced: got taken=%b meta=%b expected taken=1 meta=000101", predTaken, predMeta); end
`else
    fetch(32'h204);
    testsRun++; if (predTarget !== 32'h300 || predTaken !== 1'b1) begin testsFailed++; $display("[TB] FAIL ret_stored: got taken=%b target=%h expected taken=1 target=00000300", predTaken, predTarget); end
    for (int i = 0; i < 2; i++) applyStimulus(32'h204, 32'h0, 1'b0, 1'b0, 1'b1, metaOf(32'h204));
    fetch(32'h204);
    testsRun++; if (predTaken !== 1'b0 || predTarget !== 32'h208) begin testsFailed++; $display("[TB] FAIL ret_ignored: got taken=%b target=%h expected taken=0 target=00000208", predTaken, predTarget); end
`endif
  endtask

  task automatic test_clear();
    bp_clear = 1'b1;
    applyStimulus(32'h600, 32'h700, 1'b1, 1'b0, 1'b0, metaOf(32'h600));
    bp_clear = 1'b0;
    fetch(32'h40);
    testsRun++; if (predHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_old: got %b expected 0", predHit); end
    fetch(32'h600);
    testsRun++; if (predHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_upd: got %b expected 0", predHit); end
    fetch(32'h204);
    testsRun++; if (predHit !== 1'b0 || predTarget !== 32'h208) begin testsFailed++; $display("[TB] FAIL clear_ret: got hit=%b target=%h expected hit=0 target=00000208", predHit, predTarget); end
  endtask

  task automatic test_reset_mid_update();
    @(negedge clk);
    upd_pc = 32'h80; upd_target = 32'h123; upd_taken = 1'b1; upd_meta = metaOf(32'h80); upd_valid = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    upd_valid = 1'b0; upd_taken = 1'b0; rst = 1'b1;
    fetch(32'h80);
    testsRun++; if (predHit !== 1'b0 || predTarget !== 32'h84) begin testsFailed++; $display("[TB] FAIL reset_mid_update: got hit=%b target=%h expected hit=0 target=00000084", predHit, predTarget); end
  endtask

  task automatic test_gshare();
    pulseReset();
    applyStimulus(32'h300, 32'h400, 1'b1, 1'b0, 1'b0, 6'b0000_00);
    fetch(32'h40);
    testsRun++; if (gPredMeta[5:2] !== 4'd1) begin testsFailed++; $display("[TB] FAIL gshare_idx: got %h expected 1", gPredMeta[5:2]); end
    testsRun++; if (gPredHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL gshare_miss: got %b expected 0", gPredHit); end
    applyStimulus(32'h40, 32'h88, 1'b1, 1'b0, 1'b0, 6'b0001_00);
    fetch(32'h48);
    testsRun++; if (gPredHit !== 1'b1 || gPredTaken !== 1'b1) begin testsFailed++; $display("[TB] FAIL gshare_hit: got hit=%b taken=%b expected hit=1 taken=1", gPredHit, gPredTaken); end
    testsRun++; if (gPredTarget !== 32'h88) begin testsFailed++; $display("[TB] FAIL gshare_target: got %h expected 00000088", gPredTarget); end
    testsRun++; if (gPredMeta !== 6'b0001_10) begin testsFailed++; $display("[TB] FAIL gshare_meta: got %b expected 000110", gPredMeta); end
    bp_clear = 1'b1;
    @(posedge clk); #1;
    bp_clear = 1'b0;
    fetch(32'h40);
    testsRun++; if (gPredMeta[5:2] !== 4'd0) begin testsFailed++; $display("[TB] FAIL gshare_ghr_clear: got %h expected 0", gPredMeta[5:2]); end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_miss_no_alloc();
    test_same_cycle();
    test_return();
    test_clear();
    test_reset_mid_update();
    test_gshare();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
